snake_body_ctrl: RTL and testbench

//   Sequences the snake body for the VGA snake game. Holds segment cell positions,

---
 rtl/snake_body_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_snake_body_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: snake segment store, step/grow/collision FSM; pixel flags registered (1 clk), pulse inputs, no backpressure.
// Build option SNAKE_WRAP_EN: grid edges wrap instead of killing; only self-collision ends the game.
module snake_body_ctrl #(
  parameter int MAX_LEN    = 16,
  parameter int INIT_LEN   = 3,
  parameter int CELL_SHIFT = 4,
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       step_tick,
  input  logic [1:0] dir,
  input  logic       eat,
  input  logic [8:0] row,
  input  logic [9:0] col,
  output logic       snake_head,
  output logic       snake_r,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [4:0] length,
  output logic       dead
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;
  localparam logic [5:0] X_MAX    = 6'(GRID_W - 1);
  localparam logic [4:0] Y_MAX    = 5'(GRID_H - 1);
  localparam logic [5:0] X_HOME   = 6'd20;
  localparam logic [4:0] Y_HOME   = 5'd15;
  localparam logic [4:0] LEN_MAX  = 5'(MAX_LEN);
  localparam logic [4:0] LEN_INIT = 5'(INIT_LEN);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_seg_x [MAX_LEN];
  logic [4:0] r_seg_y [MAX_LEN];
  logic [4:0] r_len;
  logic [1:0] r_dir;
  logic       r_grow;

  logic       w_restart;
  logic       w_step;
  logic       w_grow_now;
  logic       w_wall;
  logic       w_self;
  logic       w_fatal;
  logic       w_body_hit;
  logic [1:0] w_dir;
  logic [5:0] w_nx;
  logic [4:0] w_ny;
  logic [5:0] w_cx;
  logic [4:0] w_cy;

  assign w_restart  = start && (r_state != S_RUN);
  assign w_step     = (r_state == S_RUN) && step_tick && !start;
  assign w_grow_now = (r_grow || eat) && (r_len < LEN_MAX);

`ifdef SNAKE_WRAP_EN
  assign w_fatal = w_self;
`else
  assign w_fatal = w_wall || w_self;
`endif

  // Next head: edge tests run on the untruncated position; the wrapped value is only kept in wrap builds.
  always_comb begin
    w_dir = dir;
    if (dir == {r_dir[1], ~r_dir[0]})
      w_dir = r_dir;
    w_nx   = r_seg_x[0];
    w_ny   = r_seg_y[0];
    w_wall = 1'b0;
    case (w_dir)
      D_UP: begin
        if (r_seg_y[0] == 5'd0) begin
          w_wall = 1'b1;
          w_ny   = Y_MAX;
        end else begin
          w_ny = r_seg_y[0] - 5'd1;
        end
      end
      D_DOWN: begin
        if (r_seg_y[0] >= Y_MAX) begin
          w_wall = 1'b1;
          w_ny   = 5'd0;
        end else begin
          w_ny = r_seg_y[0] + 5'd1;
        end
      end
      D_LEFT: begin
        if (r_seg_x[0] == 6'd0) begin
          w_wall = 1'b1;
          w_nx   = X_MAX;
        end else begin
          w_nx = r_seg_x[0] - 6'd1;
        end
      end
      default: begin
        if (r_seg_x[0] >= X_MAX) begin
          w_wall = 1'b1;
          w_nx   = 6'd0;
        end else begin
          w_nx = r_seg_x[0] + 6'd1;
        end
      end
    endcase
  end

  // The tail cell only blocks the head when it stays put, i.e. when growing on this step.
  always_comb begin
    w_self = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (((5'(k + 1) < r_len) || ((5'(k + 1) == r_len) && w_grow_now)) &&
          (r_seg_x[k] == w_nx) && (r_seg_y[k] == w_ny))
        w_self = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_step && w_fatal) w_state_nxt = S_DEAD;
      S_DEAD:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= X_HOME - 6'(i);
        r_seg_y[i] <= Y_HOME;
      end
      r_len  <= LEN_INIT;
      r_dir  <= D_RIGHT;
      r_grow <= 1'b0;
    end else if (w_restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= X_HOME - 6'(i);
        r_seg_y[i] <= Y_HOME;
      end
      r_len  <= LEN_INIT;
      r_dir  <= D_RIGHT;
      r_grow <= 1'b0;
    end else if (w_step) begin
      r_dir <= w_dir;
      if (!w_fatal) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          r_seg_x[i] <= r_seg_x[i-1];
          r_seg_y[i] <= r_seg_y[i-1];
        end
        r_seg_x[0] <= w_nx;
        r_seg_y[0] <= w_ny;
        if (w_grow_now)
          r_len <= r_len + 5'd1;
        r_grow <= 1'b0;
      end
    end else if ((r_state == S_RUN) && eat) begin
      r_grow <= 1'b1;
    end
  end

  assign w_cx = 6'(col >> CELL_SHIFT);
  assign w_cy = 5'(row >> CELL_SHIFT);

  always_comb begin
    w_body_hit = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if ((5'(k) < r_len) && (r_seg_x[k] == w_cx) && (r_seg_y[k] == w_cy))
        w_body_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snake_head <= 1'b0;
      snake_r    <= 1'b0;
    end else begin
      snake_head <= (r_seg_x[0] == w_cx) && (r_seg_y[0] == w_cy);
      snake_r    <= w_body_hit;
    end
  end

  assign head_x = r_seg_x[0];
  assign head_y = r_seg_y[0];
  assign length = r_len;
  assign dead   = (r_state == S_DEAD);

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl: movement, reverse-ignore, growth, wall, self-hit, pixel flags, reset.
module tb_snake_body_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       step_tick = 1'b0;
  logic       eat = 1'b0;
  logic [1:0] dir = 2'd3;
  logic [8:0] row = '0;
  logic [9:0] col = '0;
  logic       snake_head;
  logic       snake_r;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [4:0] length;
  logic       dead;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snake_body_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .step_tick  (step_tick),
    .dir        (dir),
    .eat        (eat),
    .row        (row),
    .col        (col),
    .snake_head (snake_head),
    .snake_r    (snake_r),
    .head_x     (head_x),
    .head_y     (head_y),
    .length     (length),
    .dead       (dead)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int x, input int y, input int l, input int d);
    chk({tag, ".head_x"}, int'(head_x), x);
    chk({tag, ".head_y"}, int'(head_y), y);
    chk({tag, ".length"}, int'(length), l);
    chk({tag, ".dead"},   int'(dead),   d);
  endtask

  // One-cycle pulse driven between negedges; outputs are sampled at the following negedge.
  task automatic pulse(input logic s, input logic st, input logic e);
    @(negedge clk);
    start = s; step_tick = st; eat = e;
    @(negedge clk);
    start = 1'b0; step_tick = 1'b0; eat = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b1, 1'b0);
  endtask

  task automatic pix(input int r, input int c);
    @(negedge clk);
    row = 9'(r); col = 10'(c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk_pos("reset", 20, 15, 3, 0);
    chk("reset.snake_head", int'(snake_head), 0);
    chk("reset.snake_r",    int'(snake_r),    0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // step ignored while idle
    steps(1);
    chk_pos("idle_step", 20, 15, 3, 0);

    pulse(1'b1, 1'b0, 1'b0);
    dir = 2'd3;
    steps(3);
    chk_pos("run_right3", 23, 15, 3, 0);

    dir = 2'd2;
    steps(1);
    chk_pos("reverse_ignored", 24, 15, 3, 0);

    dir = 2'd3;
    pulse(1'b0, 1'b1, 1'b1);
    chk_pos("eat_with_step", 25, 15, 4, 0);
    steps(1);
    chk_pos("no_extra_growth", 26, 15, 4, 0);

    dir = 2'd0;
    steps(15);
    chk_pos("up_to_top", 26, 0, 4, 0);
    steps(1);
`ifdef SNAKE_WRAP_EN
    chk_pos("top_wrap", 26, 29, 4, 0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
`else
    chk_pos("top_wall", 26, 0, 4, 1);
    steps(1);
    chk_pos("dead_frozen", 26, 0, 4, 1);
    pulse(1'b1, 1'b0, 1'b0);
`endif
    chk_pos("restart_wall", 20, 15, 3, 0);

    // pixel flags, one clock after the scan position changes
    chk("pix_pre.snake_head", int'(snake_head), 0);
    pix(240, 320);
    chk("pix_head.snake_head", int'(snake_head), 1);
    chk("pix_head.snake_r",    int'(snake_r),    0);
    pix(240, 304);
    chk("pix_body1.snake_head", int'(snake_head), 0);
    chk("pix_body1.snake_r",    int'(snake_r),    1);
    pix(255, 303);
    chk("pix_body2.snake_r", int'(snake_r), 1);
    pix(240, 272);
    chk("pix_beyond_len.snake_r", int'(snake_r), 0);
    pix(256, 320);
    chk("pix_below.snake_head", int'(snake_head), 0);

    // eat alone sets a pending growth consumed by the next step
    dir = 2'd3;
    pulse(1'b0, 1'b0, 1'b1);
    chk_pos("eat_pending", 20, 15, 3, 0);
    steps(1);
    chk_pos("grow_pending", 21, 15, 4, 0);
    pulse(1'b0, 1'b1, 1'b1);
    chk_pos("grow_to5", 22, 15, 5, 0);
    dir = 2'd1; steps(1);
    dir = 2'd2; steps(1);
    chk_pos("uturn_pre", 21, 16, 5, 0);
    dir = 2'd0; steps(1);
    chk_pos("self_hit", 21, 16, 5, 1);

    // start and step together: step is dropped
    pulse(1'b1, 1'b1, 1'b0);
    chk_pos("restart_self", 20, 15, 3, 0);

    dir = 2'd3;
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1'b1);
    chk_pos("grow_to8", 25, 15, 8, 0);
    pix(240, 400);
    chk("pre_rst.snake_head", int'(snake_head), 1);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_pos("mid_run_reset", 20, 15, 3, 0);
    chk("mid_run_reset.snake_head", int'(snake_head), 0);
    chk("mid_run_reset.snake_r",    int'(snake_r),    0);
    @(negedge clk);
    rst_n = 1'b1;
    steps(1);
    chk_pos("after_reset_idle", 20, 15, 3, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
